// File: rtl/instruction_fields_decode_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fields_decode_if
// Brief    : Bus bundle between an instruction source and the field decoder.
//            All vectors are declared MSB-first with index 0 as the MSB.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fields_decode_if;

   localparam int WORD_W = 24;
   localparam int OP_W   = 6;
   localparam int REG_W  = 2;
   localparam int IMM_W  = 12;

   // Request side
   logic                in_valid;
   logic                stall;
   logic [0:WORD_W-1]   instruction;

   // Decoded fields
   logic                out_valid;
   logic [0:OP_W-1]     op;
   logic [0:REG_W-1]    Rd;
   logic [0:REG_W-1]    Rs;
   logic [0:REG_W-1]    Rt;
   logic [0:IMM_W-1]    immediate;
   logic [0:WORD_W-1]   imm_sext;
   logic [0:WORD_W-1]   imm_zext;
   logic                is_rtype;
   logic                is_itype;
   logic                is_mem;
   logic                is_branch;
   logic                is_nop;

   // Instruction source: drives the request, observes the decode
   modport master (
      output in_valid, stall, instruction,
      input  out_valid, op, Rd, Rs, Rt, immediate, imm_sext, imm_zext,
      input  is_rtype, is_itype, is_mem, is_branch, is_nop
   );

   // Decoder: consumes the request, produces the decode
   modport slave (
      input  in_valid, stall, instruction,
      output out_valid, op, Rd, Rs, Rt, immediate, imm_sext, imm_zext,
      output is_rtype, is_itype, is_mem, is_branch, is_nop
   );

endinterface
`default_nettype wire

// File: rtl/instruction_fields_decode.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fields_decode
// Brief    : Registered one-cycle slicer that splits a 24-bit instruction word
//            into opcode, register indices and immediate, plus sign/zero
//            extended immediates, opcode class flags and a NOP flag.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fields_decode (
   input  wire logic                  clk,
   input  wire logic                  rst,
   instruction_fields_decode_if.slave bus
);

   localparam int WORD_W    = 24;
   localparam int IMM_W     = 12;
   localparam int IMM_EXT_W = WORD_W - IMM_W;

   // Class is carried in the two most significant opcode bits
   localparam logic [1:0] CLASS_RTYPE  = 2'b00;
   localparam logic [1:0] CLASS_ITYPE  = 2'b01;
   localparam logic [1:0] CLASS_MEM    = 2'b10;
   localparam logic [1:0] CLASS_BRANCH = 2'b11;

   logic [1:0]       op_class;
   logic [0:IMM_W-1] imm_field;

   assign op_class  = {bus.instruction[0], bus.instruction[1]};
   assign imm_field = bus.instruction[12:23];

   // Capture the decode of an accepted word; stall freezes everything, an
   // idle cycle only drops out_valid and leaves the last fields visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.op        <= '0;
         bus.Rd        <= '0;
         bus.Rs        <= '0;
         bus.Rt        <= '0;
         bus.immediate <= '0;
         bus.imm_sext  <= '0;
         bus.imm_zext  <= '0;
         bus.is_rtype  <= 1'b0;
         bus.is_itype  <= 1'b0;
         bus.is_mem    <= 1'b0;
         bus.is_branch <= 1'b0;
         bus.is_nop    <= 1'b0;
      end else if (!bus.stall) begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.op        <= bus.instruction[0:5];
            bus.Rd        <= bus.instruction[6:7];
            bus.Rs        <= bus.instruction[8:9];
            bus.Rt        <= bus.instruction[10:11];
            bus.immediate <= imm_field;
            bus.imm_sext  <= {{IMM_EXT_W{imm_field[0]}}, imm_field};
            bus.imm_zext  <= {{IMM_EXT_W{1'b0}}, imm_field};
            bus.is_rtype  <= (op_class == CLASS_RTYPE);
            bus.is_itype  <= (op_class == CLASS_ITYPE);
            bus.is_mem    <= (op_class == CLASS_MEM);
            bus.is_branch <= (op_class == CLASS_BRANCH);
            bus.is_nop    <= (bus.instruction == '0);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fields_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fields_decode
// Brief    : Directed and randomized self-checking bench for the instruction
//            field decoder, compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fields_decode;

   logic clk;
   logic rst;

   instruction_fields_decode_if bus ();

   instruction_fields_decode dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors;
   int miscompares;

   // Reference state: last captured word, whether any capture happened since
   // reset, and the expected out_valid.
   int unsigned m_word;
   bit          m_loaded;
   bit          m_valid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output against values derived arithmetically from m_word
   task automatic check_all();
      int unsigned op, rd, rs, rt, imm, sext, cls;
      op   = (m_word >> 18) & 32'h3F;
      rd   = (m_word >> 16) & 32'h3;
      rs   = (m_word >> 14) & 32'h3;
      rt   = (m_word >> 12) & 32'h3;
      imm  = m_word & 32'hFFF;
      sext = (imm >= 2048) ? (imm + 32'hFFF000) : imm;
      cls  = op / 16;
      chk("out_valid", bus.out_valid, m_valid);
      chk("op",        bus.op,        op);
      chk("Rd",        bus.Rd,        rd);
      chk("Rs",        bus.Rs,        rs);
      chk("Rt",        bus.Rt,        rt);
      chk("immediate", bus.immediate, imm);
      chk("imm_sext",  bus.imm_sext,  sext);
      chk("imm_zext",  bus.imm_zext,  imm);
      chk("is_rtype",  bus.is_rtype,  m_loaded && cls == 0);
      chk("is_itype",  bus.is_itype,  m_loaded && cls == 1);
      chk("is_mem",    bus.is_mem,    m_loaded && cls == 2);
      chk("is_branch", bus.is_branch, m_loaded && cls == 3);
      chk("is_nop",    bus.is_nop,    m_loaded && m_word == 0);
   endtask

   // Apply one cycle of inputs, advance the model at the edge, check after it
   task automatic step(input bit r, input bit v, input bit s, input logic [23:0] w);
      rst             = r;
      bus.in_valid    = v;
      bus.stall       = s;
      bus.instruction = w;
      @(posedge clk);
      if (r) begin
         m_word   = 0;
         m_loaded = 0;
         m_valid  = 0;
      end else if (!s) begin
         m_valid = v;
         if (v) begin
            m_word   = int'(w);
            m_loaded = 1;
         end
      end
      #1;
      check_all();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      m_word      = 0;
      m_loaded    = 0;
      m_valid     = 0;
      rst             = 1'b1;
      bus.in_valid    = 1'b0;
      bus.stall       = 1'b0;
      bus.instruction = '0;
      @(negedge clk);

      // Reset state
      step(1, 0, 0, 24'h0);
      step(1, 0, 0, 24'h0);

      // Worked example word with fixed expectations
      step(0, 1, 0, 24'b010100001100101010101010);
      chk("ex1_op",    bus.op,       32'b010100);
      chk("ex1_Rs",    bus.Rs,       32'b11);
      chk("ex1_sext",  bus.imm_sext, 32'hFFFAAA);
      chk("ex1_zext",  bus.imm_zext, 32'h000AAA);
      chk("ex1_itype", bus.is_itype, 32'd1);

      // Stall for three cycles with a zero word presented
      repeat (3) step(0, 1, 1, 24'h000000);
      chk("stall_sext", bus.imm_sext, 32'hFFFAAA);
      chk("stall_nop",  bus.is_nop,   32'd0);

      // Stall released: the zero word is captured as a NOP
      step(0, 1, 0, 24'h000000);
      chk("nop_flag",  bus.is_nop,   32'd1);
      chk("nop_rtype", bus.is_rtype, 32'd1);

      // All-ones opcode and registers, positive immediate
      step(0, 1, 0, 24'hFFF7FF);
      chk("br_sext",   bus.imm_sext,  32'h0007FF);
      chk("br_branch", bus.is_branch, 32'd1);

      // Idle cycle: out_valid drops, fields hold
      step(0, 0, 0, 24'h123456);
      chk("idle_imm", bus.immediate, 32'h7FF);

      // Reset wins over stall and in_valid
      step(1, 1, 1, 24'h89ABCD);
      step(0, 1, 0, 24'h89ABCD);
      // Mid-stream reset discards the word presented alongside it
      step(1, 1, 0, 24'h4A5B6C);
      step(0, 0, 0, 24'h4A5B6C);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 19) == 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) == 0),
              24'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instruction_fields_decode.md
INSTRUCTION_FIELDS_DECODE -- requirements
Module: instruction_fields

Interface
REQ-001 SHALL use one clock and one reset: the reset is synchronous and active-high; all state changes on the rising clock edge.
REQ-002 SHALL declare all vectors MSB-first with index 0 as MSB ([0:N-1]).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  instruction present this cycle.
REQ-006 stall  input  1  hold all registered outputs.
REQ-007 instruction  input  24  raw instruction word.
REQ-008 out_valid  output  1  decoded fields valid.
REQ-009 op  output  6  opcode.
REQ-010 Rd  output  2  destination register index.
REQ-011 Rs  output  2  first source register index.
REQ-012 Rt  output  2  second source register index.
REQ-013 immediate  output  12  raw immediate field.
REQ-014 imm_sext  output  24  immediate sign-extended from immediate[0].
REQ-015 imm_zext  output  24  immediate zero-extended.
REQ-016 is_rtype, is_itype, is_mem, is_branch  output  1 each  one-hot opcode class.
REQ-017 is_nop  output  1  instruction word all zeros.

Function
REQ-018 Field layout, MSB-first: op=instruction[0:5], Rd=[6:7], Rs=[8:9], Rt=[10:11], immediate=[12:23].
REQ-019 Class from op[0:1]: 00 -> is_rtype, 01 -> is_itype, 10 -> is_mem, 11 -> is_branch; exactly one class flag high whenever out_valid=1.
REQ-020 imm_sext: bits [0:11] all equal immediate[0], bits [12:23] equal immediate; imm_zext: bits [0:11]=0, bits [12:23]=immediate.
REQ-021 is_nop=1 iff all 24 instruction bits are 0; a NOP still decodes as op=0, class is_rtype=1.
REQ-022 Latency: exactly 1 cycle; fields captured on the edge where in_valid=1 and stall=0 appear on outputs after that edge.
REQ-023 out_valid after an edge = in_valid sampled at that edge, when stall=0 and rst=0.
REQ-024 When in_valid=0 and stall=0, out_valid goes 0 and all other outputs hold their last values.
REQ-025 When stall=1 and rst=0, all outputs, out_valid included, hold; the instruction and in_valid inputs are ignored that cycle.
REQ-026 Decode is purely a field slice; no opcode is illegal and no op value alters field extraction.
REQ-027 No combinational path from inputs to outputs.

Reset
REQ-028 While rst=1 at a rising edge, all outputs go to 0, including out_valid, op, Rd, Rs, Rt, immediate, imm_sext, imm_zext and all class flags, with is_nop=0.
REQ-029 rst has priority over stall and in_valid.
REQ-030 The first capture after reset occurs on the first edge with rst=0, in_valid=1 and stall=0.
REQ-031 rst asserted mid-stream discards the pending instruction; there is no output for it after reset.

Verification
REQ-032 instruction=0b010100001100101010101010, in_valid=1 -> next cycle: op=010100, Rd=00, Rs=11, Rt=00, immediate=101010101010, imm_sext=0xFFFAAA, imm_zext=0x000AAA, is_itype=1, out_valid=1.
REQ-033 instruction=0x000000, in_valid=1 -> op=0, Rd=Rs=Rt=0, immediate=0, is_nop=1, is_rtype=1, out_valid=1.
REQ-034 instruction=0xFFF7FF -> op=111111, Rd=11, Rs=11, Rt=11, immediate=0x7FF, imm_sext=0x0007FF, is_branch=1.
REQ-035 Load 0x50CAAA, then stall=1 with instruction=0x000000 for 3 cycles -> outputs remain the 0x50CAAA decode; after stall drops, the next edge captures the new word.
REQ-036 rst=1 with in_valid=1 and stall=1 -> all outputs 0 on the next edge; in_valid=0 after a valid word -> out_valid=0 and fields unchanged.
